// File: rtl/cmd_pkg.sv
// Shared definitions for the command deframer and its handlers: sync bytes,
// command type codes, parser state encoding and the frame checksum step.
package cmd_pkg;

  localparam logic [7:0] SYNC0    = 8'hAA;
  localparam logic [7:0] SYNC1    = 8'h55;

  localparam logic [7:0] CMD_DAC  = 8'hFD;
  localparam logic [7:0] CMD_PWM  = 8'hFC;
  localparam logic [7:0] CMD_UART = 8'hFB;

  typedef enum logic [3:0] {
    PS_HUNT       = 4'd0,
    PS_SYNC2      = 4'd1,
    PS_TYPE       = 4'd2,
    PS_LEN_HI     = 4'd3,
    PS_LEN_LO     = 4'd4,
    PS_PAYLOAD    = 4'd5,
    PS_CSUM       = 4'd6,
    PS_EMIT_START = 4'd7,
    PS_EMIT_DATA  = 4'd8,
    PS_EMIT_DONE  = 4'd9
  } parser_state_e;

  // Plain-vector aliases so the state register stays a bare logic vector.
  localparam logic [3:0] ST_HUNT       = PS_HUNT;
  localparam logic [3:0] ST_SYNC2      = PS_SYNC2;
  localparam logic [3:0] ST_TYPE       = PS_TYPE;
  localparam logic [3:0] ST_LEN_HI     = PS_LEN_HI;
  localparam logic [3:0] ST_LEN_LO     = PS_LEN_LO;
  localparam logic [3:0] ST_PAYLOAD    = PS_PAYLOAD;
  localparam logic [3:0] ST_CSUM       = PS_CSUM;
  localparam logic [3:0] ST_EMIT_START = PS_EMIT_START;
  localparam logic [3:0] ST_EMIT_DATA  = PS_EMIT_DATA;
  localparam logic [3:0] ST_EMIT_DONE  = PS_EMIT_DONE;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte-in / command-out bus of the deframer. master = parser side,
// slave = link receiver plus command handlers.
interface cmd_frame_parser_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_start;
  logic        cmd_data_valid;
  logic        cmd_done;
  logic        cmd_ready;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_type, cmd_length, cmd_data, cmd_data_index,
           cmd_start, cmd_data_valid, cmd_done, frame_err, overrun, busy
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_type, cmd_length, cmd_data, cmd_data_index,
           cmd_start, cmd_data_valid, cmd_done, frame_err, overrun, busy
  );

endinterface

// File: rtl/cmd_payload_ram.sv
// Payload buffer: simple dual-port, synchronous write, registered read whose
// output holds whenever re is low.
module cmd_payload_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// Command deframer: validates AA 55 type len payload csum frames into a buffer
// and replays only checksum-correct frames on the shared cmd_* bus.
module cmd_frame_parser
  import cmd_pkg::*;
#(
  parameter int MAX_LEN     = 256,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic                clk,
  input logic                rst_n,
  cmd_frame_parser_if.master bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic [3:0]    state_r, state_nxt;
  logic [7:0]    type_r, type_nxt;
  logic [15:0]   len_r, len_nxt;
  logic [15:0]   idx_r, idx_nxt;
  logic [7:0]    csum_r, csum_nxt;
  logic [TW-1:0] tmo_r, tmo_nxt;
  logic [15:0]   rd_idx_r, rd_idx_nxt;
  logic          dvalid_r, dvalid_nxt;
  logic          start_r, start_nxt;
  logic          done_r, done_nxt;
  logic          ferr_r, ferr_nxt;
  logic          ovr_r, ovr_nxt;
  logic          busy_r;
  logic [7:0]    ctype_r, ctype_nxt;
  logic [15:0]   clen_r, clen_nxt;

  logic [15:0]   len_rx_s;
  logic [7:0]    csum_add_s;
  logic [15:0]   rd_idx_inc_s;
  logic          in_frame_s;
  logic          in_emit_s;
  logic          ram_we_s;
  logic          ram_re_s;
  logic [AW-1:0] ram_raddr_s;
  logic [7:0]    ram_rdata_s;

  assign len_rx_s     = {len_r[15:8], bus.rx_data};
  assign csum_add_s   = csum_add(csum_r, bus.rx_data);
  assign rd_idx_inc_s = rd_idx_r + 16'd1;
  assign in_frame_s   = (state_r >= ST_SYNC2) && (state_r <= ST_CSUM);
  assign in_emit_s    = (state_r >= ST_EMIT_START) && (state_r <= ST_EMIT_DONE);
  assign ram_we_s     = (state_r == ST_PAYLOAD) && bus.rx_valid;

  cmd_payload_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_s),
    .waddr (idx_r[AW-1:0]),
    .wdata (bus.rx_data),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Receive and replay FSM next-state and datapath decode.
  always_comb begin
    state_nxt   = state_r;
    type_nxt    = type_r;
    len_nxt     = len_r;
    idx_nxt     = idx_r;
    csum_nxt    = csum_r;
    tmo_nxt     = tmo_r;
    rd_idx_nxt  = rd_idx_r;
    dvalid_nxt  = dvalid_r;
    ctype_nxt   = ctype_r;
    clen_nxt    = clen_r;
    start_nxt   = 1'b0;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    ovr_nxt     = 1'b0;
    ram_re_s    = 1'b0;
    ram_raddr_s = {AW{1'b0}};

    case (state_r)
      ST_HUNT: begin
        csum_nxt = 8'h00;
        idx_nxt  = 16'h0000;
        if (bus.rx_valid && (bus.rx_data == SYNC0)) begin
          state_nxt = ST_SYNC2;
        end else begin
          state_nxt = ST_HUNT;
        end
      end
      ST_SYNC2: begin
        if (!bus.rx_valid) begin
          state_nxt = ST_SYNC2;
        end else if (bus.rx_data == SYNC1) begin
          state_nxt = ST_TYPE;
        end else if (bus.rx_data == SYNC0) begin
          state_nxt = ST_SYNC2;
        end else begin
          state_nxt = ST_HUNT;
        end
      end
      ST_TYPE: begin
        if (bus.rx_valid) begin
          type_nxt  = bus.rx_data;
          csum_nxt  = bus.rx_data;
          state_nxt = ST_LEN_HI;
        end else begin
          state_nxt = ST_TYPE;
        end
      end
      ST_LEN_HI: begin
        if (bus.rx_valid) begin
          len_nxt   = {bus.rx_data, 8'h00};
          csum_nxt  = csum_add_s;
          state_nxt = ST_LEN_LO;
        end else begin
          state_nxt = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (!bus.rx_valid) begin
          state_nxt = ST_LEN_LO;
        end else begin
          len_nxt  = len_rx_s;
          csum_nxt = csum_add_s;
          idx_nxt  = 16'h0000;
          if (len_rx_s > MAX_LEN_W) begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_HUNT;
          end else if (len_rx_s == 16'h0000) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!bus.rx_valid) begin
          state_nxt = ST_PAYLOAD;
        end else begin
          csum_nxt = csum_add_s;
          idx_nxt  = idx_r + 16'd1;
          if (idx_r == (len_r - 16'd1)) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_CSUM: begin
        if (!bus.rx_valid) begin
          state_nxt = ST_CSUM;
        end else if (bus.rx_data == csum_r) begin
          state_nxt = ST_EMIT_START;
        end else begin
          ferr_nxt  = 1'b1;
          state_nxt = ST_HUNT;
        end
      end
      ST_EMIT_START: begin
        rd_idx_nxt = 16'h0000;
        if (bus.cmd_ready) begin
          start_nxt = 1'b1;
          ctype_nxt = type_r;
          clen_nxt  = len_r;
          if (len_r == 16'h0000) begin
            state_nxt = ST_EMIT_DONE;
          end else begin
            state_nxt = ST_EMIT_DATA;
          end
        end else begin
          state_nxt = ST_EMIT_START;
        end
      end
      ST_EMIT_DATA: begin
        // First cycle here only prefetches byte 0; afterwards each transfer
        // prefetches the next byte so beats can go out back to back.
        if (!dvalid_r) begin
          dvalid_nxt  = 1'b1;
          rd_idx_nxt  = 16'h0000;
          ram_re_s    = 1'b1;
          ram_raddr_s = {AW{1'b0}};
        end else if (bus.cmd_ready) begin
          if (rd_idx_r == (len_r - 16'd1)) begin
            dvalid_nxt = 1'b0;
            done_nxt   = 1'b1;
            state_nxt  = ST_EMIT_DONE;
          end else begin
            rd_idx_nxt  = rd_idx_inc_s;
            ram_re_s    = 1'b1;
            ram_raddr_s = rd_idx_inc_s[AW-1:0];
          end
        end else begin
          state_nxt = ST_EMIT_DATA;
        end
      end
      ST_EMIT_DONE: begin
        // Data frames arrive with the done pulse already issued; zero-length
        // frames issue it here.
        if (done_r) begin
          state_nxt = ST_HUNT;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = ST_EMIT_DONE;
        end
      end
      default: begin
        state_nxt = ST_HUNT;
      end
    endcase

    if (!in_frame_s) begin
      tmo_nxt = {TW{1'b0}};
    end else if (bus.rx_valid) begin
      tmo_nxt = {TW{1'b0}};
    end else if (tmo_r == TMO_LAST) begin
      tmo_nxt   = {TW{1'b0}};
      ferr_nxt  = 1'b1;
      state_nxt = ST_HUNT;
    end else begin
      tmo_nxt = tmo_r + TW'(1);
    end

    if (in_emit_s && bus.rx_valid) begin
      ovr_nxt = 1'b1;
    end else begin
      ovr_nxt = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_HUNT;
      type_r   <= 8'h00;
      len_r    <= 16'h0000;
      idx_r    <= 16'h0000;
      csum_r   <= 8'h00;
      tmo_r    <= {TW{1'b0}};
      rd_idx_r <= 16'h0000;
      dvalid_r <= 1'b0;
      start_r  <= 1'b0;
      done_r   <= 1'b0;
      ferr_r   <= 1'b0;
      ovr_r    <= 1'b0;
      busy_r   <= 1'b0;
      ctype_r  <= 8'h00;
      clen_r   <= 16'h0000;
    end else begin
      state_r  <= state_nxt;
      type_r   <= type_nxt;
      len_r    <= len_nxt;
      idx_r    <= idx_nxt;
      csum_r   <= csum_nxt;
      tmo_r    <= tmo_nxt;
      rd_idx_r <= rd_idx_nxt;
      dvalid_r <= dvalid_nxt;
      start_r  <= start_nxt;
      done_r   <= done_nxt;
      ferr_r   <= ferr_nxt;
      ovr_r    <= ovr_nxt;
      busy_r   <= (state_nxt != ST_HUNT);
      ctype_r  <= ctype_nxt;
      clen_r   <= clen_nxt;
    end
  end

  assign bus.cmd_type       = ctype_r;
  assign bus.cmd_length     = clen_r;
  assign bus.cmd_data       = ram_rdata_s;
  assign bus.cmd_data_index = rd_idx_r;
  assign bus.cmd_start      = start_r;
  assign bus.cmd_data_valid = dvalid_r;
  assign bus.cmd_done       = done_r;
  assign bus.frame_err      = ferr_r;
  assign bus.overrun        = ovr_r;
  assign bus.busy           = busy_r;

endmodule
